// File: rtl/input_multiplier_pkg.sv
// Shared constants for the input-side BCD-to-binary converter: default width,
// digit width, FSM state encoding and a digit-validity helper.
package input_multiplier_pkg;

  localparam int N_DEFAULT = 16;
  localparam int DIGIT_W   = 4;

  typedef enum logic [2:0] {
    S_C3 = 3'd0,
    S_C2 = 3'd1,
    S_C1 = 3'd2,
    S_C0 = 3'd3,
    S_FN = 3'd4
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/input_multiplier_mul10_add.sv
// One Horner step of the conversion: result = acc*10 + digit, truncated to N bits.
module mul10_add
  import input_multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]       acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [N-1:0]       result
);

  // x10 as x8 + x2 keeps this a pair of shifts and adders, no multiplier.
  assign result = (acc << 3) + (acc << 1) + {{(N-DIGIT_W){1'b0}}, digit};

endmodule

// File: rtl/input_multiplier.sv
// Sequential BCD-to-binary converter: four digits captured on load, folded MSD first.
// Optional digit validity checking is enabled by defining INPUT_MULTIPLIER_CHECK_EN.
//
// Handshake: load is a single-cycle strobe accepted in any state (a load while busy
// aborts and restarts); done pulses for exactly one cycle with data valid alongside it.
module input_multiplier
  import input_multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] bcd0,
  input  logic [DIGIT_W-1:0] bcd1,
  input  logic [DIGIT_W-1:0] bcd2,
  input  logic [DIGIT_W-1:0] bcd3,
  output logic [N-1:0]       data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         state_dbg
);

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       acc;
  logic [N-1:0]       step_value;
  logic [DIGIT_W-1:0] d0, d1, d2, d3;
  logic [DIGIT_W-1:0] sel_digit;
  logic               final_bad;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_FN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sel_digit  = '0;
    case (state)
      S_C3: begin sel_digit = d3; state_next = S_C2; end
      S_C2: begin sel_digit = d2; state_next = S_C1; end
      S_C1: begin sel_digit = d1; state_next = S_C0; end
      S_C0: begin sel_digit = d0; state_next = S_FN; end
      default: state_next = S_FN;
    endcase
    if (load) begin
      state_next = S_C3;
    end
  end

  assign busy      = (state != S_FN);
  assign state_dbg = state;

  mul10_add #(.N(N)) u_mul10_add (
    .acc    (acc),
    .digit  (sel_digit),
    .result (step_value)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      acc  <= '0;
      d0   <= '0;
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        d0  <= bcd0;
        d1  <= bcd1;
        d2  <= bcd2;
        d3  <= bcd3;
        acc <= '0;
      end else begin
        case (state)
          S_C3, S_C2, S_C1: acc <= step_value;
          S_C0: begin
            data <= final_bad ? '0 : step_value;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef INPUT_MULTIPLIER_CHECK_EN
  logic err_flag;
  logic step_bad;

  // sel_digit is zero outside the step states, so step_bad is only live mid-conversion.
  assign step_bad  = !is_bcd(sel_digit);
  assign final_bad = err_flag | step_bad;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err_flag <= 1'b0;
      error    <= 1'b0;
    end else if (load) begin
      err_flag <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        S_C3, S_C2, S_C1: err_flag <= err_flag | step_bad;
        S_C0:             error    <= final_bad;
        default: ;
      endcase
    end
  end
`else
  assign final_bad = 1'b0;
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_input_multiplier.sv
// Self-checking bench for input_multiplier: directed scenarios plus randomized
// conversions compared against a decimal-arithmetic reference model.
module tb_input_multiplier;

  localparam int N = 16;

  logic         Clock;
  logic         Reset;
  logic         load;
  logic [3:0]   bcd0, bcd1, bcd2, bcd3;
  logic [N-1:0] data;
  logic         busy;
  logic         done;
  logic         error;
  logic [2:0]   state_dbg;

  int tests;
  int fails;
  logic [N-1:0] last_data;
  logic [N-1:0] exp_q[$];

  input_multiplier #(.N(N)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (load),
    .bcd0      (bcd0),
    .bcd1      (bcd1),
    .bcd2      (bcd2),
    .bcd3      (bcd3),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: the operand is simply the decimal number the digits spell.
  function automatic logic [N-1:0] model_value(input int unsigned d3, d2, d1, d0);
    int unsigned v;
    v = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
`ifdef INPUT_MULTIPLIER_CHECK_EN
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) v = 0;
`endif
    return v[N-1:0];
  endfunction

  function automatic logic model_error(input int unsigned d3, d2, d1, d0);
`ifdef INPUT_MULTIPLIER_CHECK_EN
    return (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9);
`else
    return (d3 > 99999 && d2 > 99999 && d1 > 99999 && d0 > 99999);
`endif
  endfunction

  // Drivers
  task automatic do_load_now(input int unsigned d3, d2, d1, d0);
    bcd3 = d3[3:0];
    bcd2 = d2[3:0];
    bcd1 = d1[3:0];
    bcd0 = d0[3:0];
    load = 1'b1;
    @(negedge Clock);
    load = 1'b0;
  endtask

  task automatic do_load(input int unsigned d3, d2, d1, d0);
    @(negedge Clock);
    do_load_now(d3, d2, d1, d0);
  endtask

  // Counts negedges until done is seen (bounded); ends on the done cycle.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 20 && done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge Clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge Clock);
    tests++; if (data !== '0) begin fails++; $display("FAIL reset_data got=%0d exp=0", data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error); end
    tests++; if (state_dbg !== 3'd4) begin fails++; $display("FAIL reset_state got=%0d exp=4", state_dbg); end
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
    last_data = '0;
  endtask

  task automatic test_basic;
    int lat, bc;
    do_load(1, 2, 3, 4);
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL basic_start busy=%b done=%b exp=1/0", busy, done); end
    wait_done(lat, bc);
    tests++; if (lat !== 4) begin fails++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    tests++; if (bc !== 4) begin fails++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    tests++; if (data !== 16'd1234) begin fails++; $display("FAIL basic_data got=%0d exp=1234", data); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error got=%b exp=0", error); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
    @(negedge Clock);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got=%b exp=0", done); end
    tests++; if (data !== 16'd1234) begin fails++; $display("FAIL basic_data_hold got=%0d exp=1234", data); end
    last_data = 16'd1234;
  endtask

  task automatic test_extremes;
    int lat, bc;
    do_load(9, 9, 9, 9);
    wait_done(lat, bc);
    tests++; if (lat !== 4 || data !== 16'd9999) begin fails++; $display("FAIL max_value lat=%0d data=%0d exp=4/9999", lat, data); end
    do_load(0, 0, 0, 0);
    wait_done(lat, bc);
    tests++; if (lat !== 4 || data !== 16'd0) begin fails++; $display("FAIL zero_value lat=%0d data=%0d exp=4/0", lat, data); end
    last_data = '0;
    do_load(0, 8, 0, 9);
    wait_done(lat, bc);
    tests++; if (data !== 16'd809) begin fails++; $display("FAIL inner_zero got=%0d exp=809", data); end
    last_data = 16'd809;
  endtask

  task automatic test_abort;
    int lat, bc;
    do_load(5, 6, 7, 8);
    tests++; if (data !== last_data || done !== 1'b0) begin fails++; $display("FAIL abort_hold1 data=%0d done=%b exp=%0d/0", data, done, last_data); end
    do_load(0, 0, 4, 2);
    tests++; if (data !== last_data || done !== 1'b0) begin fails++; $display("FAIL abort_hold2 data=%0d done=%b exp=%0d/0", data, done, last_data); end
    wait_done(lat, bc);
    tests++; if (lat !== 4) begin fails++; $display("FAIL abort_latency got=%0d exp=4", lat); end
    tests++; if (data !== 16'd42) begin fails++; $display("FAIL abort_data got=%0d exp=42", data); end
    last_data = 16'd42;
  endtask

  task automatic test_load_held;
    int dones;
    dones = 0;
    @(negedge Clock);
    bcd3 = 4'd3; bcd2 = 4'd3; bcd1 = 4'd3; bcd0 = 4'd3;
    load = 1'b1;
    repeat (8) begin
      @(negedge Clock);
      if (done === 1'b1) dones++;
    end
    load = 1'b0;
    tests++; if (dones !== 0 || busy !== 1'b1) begin fails++; $display("FAIL load_held dones=%0d busy=%b exp=0/1", dones, busy); end
    tests++; if (data !== last_data) begin fails++; $display("FAIL load_held_data got=%0d exp=%0d", data, last_data); end
    repeat (5) @(negedge Clock);
    last_data = 16'd3333;
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    do_load(1, 1, 1, 1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    tests++; if (data !== '0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL reset_mid data=%0d busy=%b done=%b error=%b exp=0/0/0/0", data, busy, done, error);
    end
    @(negedge Clock);
    Reset = 1'b0;
    repeat (8) begin
      @(negedge Clock);
      if (done === 1'b1) dones++;
    end
    tests++; if (dones !== 0 || data !== '0) begin fails++; $display("FAIL reset_mid_after dones=%0d data=%0d exp=0/0", dones, data); end
    last_data = '0;
  endtask

  task automatic test_invalid;
    int lat, bc;
`ifdef INPUT_MULTIPLIER_CHECK_EN
    do_load(1, 10, 3, 4);
    wait_done(lat, bc);
    tests++; if (lat !== 4 || data !== '0 || error !== 1'b1) begin fails++; $display("FAIL invalid_digit lat=%0d data=%0d error=%b exp=4/0/1", lat, data, error); end
    @(negedge Clock);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL error_held got=%b exp=1", error); end
    do_load(0, 0, 0, 7);
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL error_clear_on_load got=%b exp=0", error); end
    wait_done(lat, bc);
    tests++; if (data !== 16'd7 || error !== 1'b0) begin fails++; $display("FAIL after_error data=%0d error=%b exp=7/0", data, error); end
    last_data = 16'd7;
`else
    do_load(0, 0, 1, 15);
    wait_done(lat, bc);
    tests++; if (lat !== 4 || data !== 16'd25 || error !== 1'b0) begin fails++; $display("FAIL raw_digit lat=%0d data=%0d error=%b exp=4/25/0", lat, data, error); end
    last_data = 16'd25;
`endif
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    int unsigned d[4];
    logic exp_err;
    logic b2b;
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      exp_q.push_back(model_value(d[3], d[2], d[1], d[0]));
      exp_err = model_error(d[3], d[2], d[1], d[0]);
      if (b2b) do_load_now(d[3], d[2], d[1], d[0]);
      else do_load(d[3], d[2], d[1], d[0]);
      wait_done(lat, bc);
      tests++;
      if (lat !== 4 || data !== exp_q[0] || error !== exp_err) begin
        fails++;
        $display("FAIL random_%0d digits=%0d%0d%0d%0d lat=%0d data=%0d error=%b exp=4/%0d/%b",
                 i, d[3], d[2], d[1], d[0], lat, data, error, exp_q[0], exp_err);
      end
      void'(exp_q.pop_front());
      b2b = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    load  = 1'b0;
    bcd0  = '0;
    bcd1  = '0;
    bcd2  = '0;
    bcd3  = '0;
    last_data = '0;
    test_reset;
    test_basic;
    test_extremes;
    test_abort;
    test_load_held;
    test_reset_mid;
    test_invalid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
